// File: rtl/lr3_disp_scan_ctrl.sv
// Scan controller for the shared 8-digit 7-segment display: captures switch values into a
// shift buffer on button pulses and time-multiplexes them onto CAT/AN with blanking gaps.
module lr3_disp_scan_ctrl #(
    parameter int unsigned SHOW_TICKS  = 3,
    parameter int unsigned BLANK_TICKS = 1,
    parameter bit          LZB         = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_CE,
    input  logic       DISP_CE,
    input  logic [3:0] DAT_I,
    input  logic       CLR,
    output logic [6:0] CAT,
    output logic [7:0] AN,
    output logic [3:0] DIG_CNT,
    output logic       FULL
);

    localparam int unsigned TMAX = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_TICKS == 0) ? 0 : BLANK_TICKS - 1);

    typedef enum logic {StBlank, StShow} state_e;

    state_e          st_q, st_d;
    logic [2:0]      idx_q, idx_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [7:0][3:0] dig_q, dig_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            full_q, full_d;
    logic [7:0]      an_q, an_d;
    logic [6:0]      cat_q, cat_d;
    logic [3:0]      lim;
    logic            show_ok;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        dig_d = dig_q;
        cnt_d = cnt_q;
        if (CLR) begin
            dig_d = '0;
            cnt_d = '0;
        end else if (BTN_CE) begin
            dig_d = {dig_q[6:0], DAT_I};
            if (cnt_q != 4'd8) cnt_d = cnt_q + 4'd1;
        end
        full_d = (cnt_d == 4'd8);
    end

    always_comb begin
        st_d   = st_q;
        idx_d  = idx_q;
        tick_d = tick_q;
        if (DISP_CE) begin
            case (st_q)
                StShow: begin
                    if (tick_q == SHOW_LAST) begin
                        tick_d = '0;
                        // Without a gap, step straight to the next digit.
                        if (BLANK_TICKS == 0) idx_d = idx_q + 3'd1;
                        else                  st_d  = StBlank;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    if (tick_q == BLANK_LAST) begin
                        st_d   = StShow;
                        tick_d = '0;
                        idx_d  = idx_q + 3'd1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Digit 0 is always lit so an empty buffer still shows "0".
    assign lim     = (cnt_q == 4'd0) ? 4'd1 : cnt_q;
    assign show_ok = !LZB || ({1'b0, idx_q} < lim);

    always_comb begin
        an_d  = 8'hFF;
        cat_d = 7'h7F;
        if (st_q == StShow) begin
            cat_d = seg7(dig_q[idx_q]);
            if (show_ok) an_d = ~(8'b1 << idx_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st_q   <= StBlank;
            idx_q  <= '0;
            tick_q <= '0;
            dig_q  <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            an_q   <= 8'hFF;
            cat_q  <= 7'h7F;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            tick_q <= tick_d;
            dig_q  <= dig_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            an_q   <= an_d;
            cat_q  <= cat_d;
        end
    end

    assign CAT     = cat_q;
    assign AN      = an_q;
    assign DIG_CNT = cnt_q;
    assign FULL    = full_q;

endmodule

// File: doc/lr3_disp_scan_ctrl.md
Name: lr3_disp_scan_ctrl

Overview:
Scan controller for the 8-digit, 7-segment display shared by all LR3 digits. Captures 4-bit switch values into an 8-digit shift buffer on each filtered button pulse. Time-multiplexes the buffer onto the common CAT/AN lines, advancing on each display clock-enable pulse, with a blanking gap between digits to suppress ghosting. Sits between the button-filter/display-CE generators and the board display pins.

Parameters:
SHOW_TICKS, 3, DISP_CE pulses each digit is driven (≥1)
BLANK_TICKS, 1, DISP_CE pulses of all-anodes-off between digits (≥0; 0 = no gap)
LZB, 1, 1 = digits not yet entered are blanked; 0 = all 8 digits always shown

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
BTN_CE  in  1  one-cycle pulse, filtered button press
DISP_CE  in  1  one-cycle pulse, display scan tick
DAT_I  in  4  digit value to capture (switches)
CLR  in  1  synchronous clear of buffer and count (level, checked every cycle)
CAT  out  7  segments g..a, active-low (CAT[0]=a, CAT[6]=g)
AN  out  8  digit anodes, active-low, AN[0] = rightmost digit
DIG_CNT  out  4  number of digits entered, 0..8
FULL  out  1  DIG_CNT == 8

Behaviour:
- Reset (RST=1 at a CLK edge): digit buffer all 0, DIG_CNT=0, FULL=0, scan state BLANK, digit index 0, tick counter 0, AN=8'hFF, CAT=7'h7F. Reset overrides every other input.
- Entry, on BTN_CE=1: buf[7:1]<=buf[6:0]; buf[0]<=DAT_I; DIG_CNT<=min(DIG_CNT+1,8). At 8 digits, shifting continues (oldest digit lost) and DIG_CNT saturates at 8.
- CLR=1: buffer<=0, DIG_CNT<=0. CLR has priority over a same-cycle BTN_CE; the scan FSM is unaffected.
- Scan FSM, advancing only on DISP_CE=1:
  - SHOW: tick++. When tick == SHOW_TICKS-1, go to BLANK with tick=0. If BLANK_TICKS==0, go directly to SHOW of index+1 instead.
  - BLANK: tick++. When tick == BLANK_TICKS-1, go to SHOW with tick=0 and index=(index+1) mod 8 (wraps 7→0).
  - First SHOW after reset is index 1, because reset enters BLANK at index 0. Tests account for this.
- Outputs are registered, one CLK after the state/index/buffer change:
  - In BLANK: AN=8'hFF, CAT=7'h7F.
  - In SHOW: AN = ~(1<<index).
  - If LZB=1 and index ≥ max(DIG_CNT,1): AN=8'hFF (blanked). Digit 0 is always shown, so an empty buffer shows "0".
  - CAT = hex decode of buf[index], active-low:
    - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
    - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex, bits g..a).
- A BTN_CE and a DISP_CE in the same cycle are both processed. The displayed segments reflect the new buffer contents from the next registered update.
- DIG_CNT and FULL are registered and update in the same cycle as the buffer.
- Exactly one AN bit low, or none; never more than one.

Test Plan:
1. Reset, then no input. AN=FF, CAT=7F, DIG_CNT=0. After 1 DISP_CE (BLANK_TICKS=1), SHOW index 1 is blanked (LZB). Continue pulsing DISP_CE until index 0 → AN=FE, CAT=40 ("0").
2. BTN_CE with DAT_I=3, then DAT_I=A. Response: DIG_CNT=2, buf[1]=3, buf[0]=A. During SHOW index 0: AN=FE, CAT=08. During SHOW index 1: AN=FD, CAT=30. Index 2..7 stay FF.
3. Ten BTN_CE pulses with DAT_I=0..9. Response: DIG_CNT=8, FULL=1, buf[7..0]=2,3,4,5,6,7,8,9. Index 7 shows CAT=24.
4. CLR and BTN_CE in the same cycle with 5 digits loaded. Response: DIG_CNT=0, buffer 0, FULL=0.
5. Scan timing with SHOW_TICKS=3, BLANK_TICKS=1, DISP_CE every 4 CLK. Each digit's AN is low for exactly 12 CLK, followed by 4 CLK of FF. Index sequence wraps 7→0. At most one AN bit is ever low.
6. RST asserted mid-SHOW at index 5. Response: the next cycle gives AN=FF, CAT=7F, DIG_CNT=0, and the scan restarts from BLANK index 0.
